// File: rtl/alg_amba_vip_base_vldrdy_arb_if.sv
// Valid/ready bundle shared by NUM_REQ requesters and the single output stream
// of the burst-locking round-robin arbiter.
interface alg_amba_vip_base_vldrdy_arb_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int IDX_W      = $clog2(NUM_REQ)
);
  logic [NUM_REQ-1:0]            req_en;
  logic [NUM_REQ-1:0]            in_valid;
  logic [NUM_REQ*DATA_WIDTH-1:0] in_data;
  logic [NUM_REQ-1:0]            in_last;
  logic [NUM_REQ-1:0]            in_ready;
  logic                          out_valid;
  logic [DATA_WIDTH-1:0]         out_data;
  logic                          out_last;
  logic [IDX_W-1:0]              out_src;
  logic                          out_ready;
  logic                          busy;
  logic [IDX_W-1:0]              owner;

  modport master (
    output req_en, in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_last, out_src, busy, owner
  );

  modport slave (
    input  req_en, in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_last, out_src, busy, owner
  );
endinterface

// File: rtl/alg_amba_vip_base_vldrdy_arb.sv
// Round-robin arbiter that locks the grant for a whole burst and feeds one
// registered valid/ready output slot from NUM_REQ requesters.
module alg_amba_vip_base_vldrdy_arb #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_BEATS  = 0
) (
  input  logic                           clk,
  input  logic                           rstn,
  alg_amba_vip_base_vldrdy_arb_if.slave  bus
);
  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int SUM_W = IDX_W + 1;
  localparam int CNT_W = (MAX_BEATS > 0) ? $clog2(MAX_BEATS + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = (MAX_BEATS > 0) ? CNT_W'(MAX_BEATS) : '1;

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t                  state, state_nx;
  logic [IDX_W-1:0]        rr_ptr, rr_nx;
  logic [IDX_W-1:0]        owner_r, owner_nx;
  logic [CNT_W-1:0]        beat_cnt, cnt_nx, cnt_inc;

  logic [NUM_REQ-1:0]      cand;
  logic [NUM_REQ-1:0]      in_ready_c;
  logic [SUM_W-1:0]        sum;
  logic                    found, slot_free, grant, xfer, cap, rel;
  logic [IDX_W-1:0]        gnt_idx;
  logic                    sel_valid, sel_last;
  logic [DATA_WIDTH-1:0]   sel_data;

  logic                    vld_p1;
  logic [DATA_WIDTH-1:0]   data_p1;
  logic                    last_p1;
  logic [IDX_W-1:0]        src_p1;

  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
    return (i == IDX_W'(NUM_REQ - 1)) ? '0 : i + IDX_W'(1);
  endfunction

  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      owner_r  <= '0;
      beat_cnt <= '0;
    end else begin
      state    <= state_nx;
      rr_ptr   <= rr_nx;
      owner_r  <= owner_nx;
      beat_cnt <= cnt_nx;
    end
  end

  always_comb begin
    cand       = bus.in_valid & bus.req_en;
    found      = 1'b0;
    gnt_idx    = rr_ptr;
    sum        = '0;
    in_ready_c = '0;
    sel_valid  = 1'b0;
    sel_last   = 1'b0;
    sel_data   = '0;
    state_nx   = state;
    rr_nx      = rr_ptr;
    owner_nx   = owner_r;
    cnt_nx     = beat_cnt;

    // The owner keeps the grant through bubbles; req_en only gates new arbitration.
    if (state == LOCKED) begin
      found   = 1'b1;
      gnt_idx = owner_r;
    end else begin
      for (int k = 0; k < NUM_REQ; k++) begin
        sum = {1'b0, rr_ptr} + SUM_W'(k);
        if (sum >= SUM_W'(NUM_REQ)) sum = sum - SUM_W'(NUM_REQ);
        if (!found && cand[sum[IDX_W-1:0]]) begin
          found   = 1'b1;
          gnt_idx = sum[IDX_W-1:0];
        end
      end
    end

    slot_free = !vld_p1 || bus.out_ready;
    grant     = found && slot_free && !rstn;

    for (int k = 0; k < NUM_REQ; k++) begin
      if (gnt_idx == IDX_W'(k)) begin
        in_ready_c[k] = grant;
        sel_valid     = bus.in_valid[k];
        sel_last      = bus.in_last[k];
        sel_data      = bus.in_data[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end

    xfer    = grant && sel_valid;
    cnt_inc = (state == LOCKED) ? ((beat_cnt == CNT_MAX) ? beat_cnt : beat_cnt + CNT_W'(1))
                                : CNT_W'(1);
    cap     = (MAX_BEATS > 0) && (cnt_inc == CNT_MAX);
    rel     = sel_last || cap;

    if (xfer) begin
      owner_nx = gnt_idx;
      if (rel) begin
        state_nx = IDLE;
        rr_nx    = next_idx(gnt_idx);
        cnt_nx   = '0;
      end else begin
        state_nx = LOCKED;
        cnt_nx   = cnt_inc;
      end
    end
  end

  // Stage 1: registered output slot
  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      vld_p1  <= 1'b0;
      data_p1 <= '0;
      last_p1 <= 1'b0;
      src_p1  <= '0;
    end else if (xfer) begin
      vld_p1  <= 1'b1;
      data_p1 <= sel_data;
      last_p1 <= rel;
      src_p1  <= gnt_idx;
    end else if (bus.out_ready) begin
      vld_p1  <= 1'b0;
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = vld_p1;
  assign bus.out_data  = data_p1;
  assign bus.out_last  = last_p1;
  assign bus.out_src   = src_p1;
  assign bus.busy      = (state == LOCKED);
  assign bus.owner     = owner_r;
endmodule

// File: tb/tb_alg_amba_vip_base_vldrdy_arb.sv
// Scoreboard bench for the burst-locking round-robin arbiter: dut_a unlimited
// bursts, dut_b with a two-beat forced release.
module tb_alg_amba_vip_base_vldrdy_arb;
  localparam int NR = 4;
  localparam int DW = 32;
  localparam int IW = 2;

  typedef struct packed {
    logic [IW-1:0] src;
    logic [DW-1:0] data;
    logic          last;
  } beat_t;

  logic clk = 1'b0;
  logic rst_a = 1'b1;
  logic rst_b = 1'b1;
  always #5 clk = ~clk;

  alg_amba_vip_base_vldrdy_arb_if #(.NUM_REQ(NR), .DATA_WIDTH(DW)) ifa ();
  alg_amba_vip_base_vldrdy_arb_if #(.NUM_REQ(NR), .DATA_WIDTH(DW)) ifb ();

  alg_amba_vip_base_vldrdy_arb #(.NUM_REQ(NR), .DATA_WIDTH(DW), .MAX_BEATS(0)) dut_a (
    .clk(clk), .rstn(rst_a), .bus(ifa.slave));
  alg_amba_vip_base_vldrdy_arb #(.NUM_REQ(NR), .DATA_WIDTH(DW), .MAX_BEATS(2)) dut_b (
    .clk(clk), .rstn(rst_b), .bus(ifb.slave));

  int checks = 0;
  int errors = 0;
  beat_t q_a[$];
  beat_t q_b[$];

  logic [DW:0]    mem [2][NR][16];
  int             n   [2][NR];
  int             h   [2][NR];
  logic [NR-1:0]  acc [2];

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endfunction

  task automatic load(input int d, input int r, input logic [DW-1:0] data, input logic last);
    mem[d][r][n[d][r]] = {last, data};
    n[d][r]++;
  endtask

  task automatic push_exp(input int d, input int src, input logic [DW-1:0] data, input logic last);
    beat_t b;
    b.src  = IW'(src);
    b.data = data;
    b.last = last;
    if (d == 0) q_a.push_back(b); else q_b.push_back(b);
  endtask

  task automatic drive(input int d, input logic [NR-1:0] v, input logic [NR*DW-1:0] dat,
                       input logic [NR-1:0] lst, input logic ordy, input logic [NR-1:0] en);
    if (d == 0) begin
      ifa.in_valid = v; ifa.in_data = dat; ifa.in_last = lst; ifa.out_ready = ordy; ifa.req_en = en;
    end else begin
      ifb.in_valid = v; ifb.in_data = dat; ifb.in_last = lst; ifb.out_ready = ordy; ifb.req_en = en;
    end
  endtask

  // One clock of requester activity: retire beats taken at the last edge, offer the next ones.
  task automatic cycle(input int d, input logic ordy, input logic [NR-1:0] en);
    logic [NR-1:0]    v, lst, rdy;
    logic [NR*DW-1:0] dat;
    @(negedge clk);
    for (int r = 0; r < NR; r++) if (acc[d][r]) h[d][r]++;
    for (int r = 0; r < NR; r++) begin
      v[r]          = (h[d][r] < n[d][r]);
      dat[r*DW +: DW] = v[r] ? mem[d][r][h[d][r]][DW-1:0] : '0;
      lst[r]        = v[r] ? mem[d][r][h[d][r]][DW] : 1'b0;
    end
    drive(d, v, dat, lst, ordy, en);
    #1;
    rdy    = (d == 0) ? ifa.in_ready : ifb.in_ready;
    acc[d] = rdy & v;
    chk("ready_onehot", 64'($countones(rdy) <= 1), 64'(1));
  endtask

  task automatic do_reset(input int d);
    @(negedge clk);
    if (d == 0) rst_a = 1'b1; else rst_b = 1'b1;
    #1;
    if (d == 0) begin
      chk("rst_out_valid", 64'(ifa.out_valid), 64'(0));
      chk("rst_busy", 64'(ifa.busy), 64'(0));
      chk("rst_in_ready", 64'(ifa.in_ready), 64'(0));
    end else begin
      chk("rst_out_valid_b", 64'(ifb.out_valid), 64'(0));
      chk("rst_busy_b", 64'(ifb.busy), 64'(0));
    end
    for (int r = 0; r < NR; r++) begin
      n[d][r] = 0;
      h[d][r] = 0;
    end
    acc[d] = '0;
    drive(d, '0, '0, '0, 1'b1, '1);
    repeat (2) @(negedge clk);
    if (d == 0) rst_a = 1'b0; else rst_b = 1'b0;
  endtask

  task automatic mon(input int d, input logic v, input logic r, input logic [DW-1:0] data,
                     input logic last, input logic [IW-1:0] src);
    beat_t e;
    int    sz;
    if (!v) return;
    sz = (d == 0) ? q_a.size() : q_b.size();
    if (sz == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_beat dut%0d actual src=%0d data=%0h required no beat", d, src, data);
      return;
    end
    e = (d == 0) ? q_a[0] : q_b[0];
    chk("out_src", 64'(src), 64'(e.src));
    chk("out_data", 64'(data), 64'(e.data));
    chk("out_last", 64'(last), 64'(e.last));
    if (r) begin
      if (d == 0) void'(q_a.pop_front()); else void'(q_b.pop_front());
    end
  endtask

  always @(negedge clk) begin
    #2;
    if (!rst_a) mon(0, ifa.out_valid, ifa.out_ready, ifa.out_data, ifa.out_last, ifa.out_src);
    if (!rst_b) mon(1, ifb.out_valid, ifb.out_ready, ifb.out_data, ifb.out_last, ifb.out_src);
  end

  initial begin
    for (int d = 0; d < 2; d++) begin
      acc[d] = '0;
      for (int r = 0; r < NR; r++) begin
        n[d][r] = 0;
        h[d][r] = 0;
      end
    end
    drive(0, '1, '0, '0, 1'b1, '1);
    drive(1, '1, '0, '0, 1'b1, '1);

    // Reset values, with every requester asking
    repeat (2) @(negedge clk);
    #1;
    chk("reset_out_valid", 64'(ifa.out_valid), 64'(0));
    chk("reset_out_data", 64'(ifa.out_data), 64'(0));
    chk("reset_out_last", 64'(ifa.out_last), 64'(0));
    chk("reset_out_src", 64'(ifa.out_src), 64'(0));
    chk("reset_busy", 64'(ifa.busy), 64'(0));
    chk("reset_owner", 64'(ifa.owner), 64'(0));
    chk("reset_in_ready", 64'(ifa.in_ready), 64'(0));
    chk("reset_in_ready_b", 64'(ifb.in_ready), 64'(0));
    drive(0, '0, '0, '0, 1'b1, '1);
    drive(1, '0, '0, '0, 1'b1, '1);
    @(negedge clk);
    rst_a = 1'b0;
    rst_b = 1'b0;

    // Requester 0 alone, 3-beat burst
    load(0, 0, 32'h0001, 1'b0); load(0, 0, 32'h0002, 1'b0); load(0, 0, 32'h0003, 1'b1);
    push_exp(0, 0, 32'h0001, 1'b0); push_exp(0, 0, 32'h0002, 1'b0); push_exp(0, 0, 32'h0003, 1'b1);
    cycle(0, 1'b1, '1);
    chk("t1_c1_busy", 64'(ifa.busy), 64'(0));
    chk("t1_c1_out_valid", 64'(ifa.out_valid), 64'(0));
    cycle(0, 1'b1, '1);
    chk("t1_c2_busy", 64'(ifa.busy), 64'(1));
    chk("t1_c2_out_valid", 64'(ifa.out_valid), 64'(1));
    cycle(0, 1'b1, '1);
    chk("t1_c3_busy", 64'(ifa.busy), 64'(1));
    cycle(0, 1'b1, '1);
    chk("t1_c4_busy", 64'(ifa.busy), 64'(0));
    chk("t1_c4_out_valid", 64'(ifa.out_valid), 64'(1));
    cycle(0, 1'b1, '1);
    chk("t1_c5_out_valid", 64'(ifa.out_valid), 64'(0));
    chk("t1_drained", 64'(q_a.size()), 64'(0));

    // rr_ptr now 1: requester 1 beats requester 0
    load(0, 0, 32'h0004, 1'b1); load(0, 1, 32'h0101, 1'b1);
    push_exp(0, 1, 32'h0101, 1'b1); push_exp(0, 0, 32'h0004, 1'b1);
    repeat (4) cycle(0, 1'b1, '1);
    chk("rr_drained", 64'(q_a.size()), 64'(0));

    // Single-beat bursts from 0,1,2 back to back
    do_reset(0);
    for (int r = 0; r < 3; r++)
      for (int b = 1; b <= 2; b++) load(0, r, DW'(r * 256 + b), 1'b1);
    push_exp(0, 0, 32'h0001, 1'b1); push_exp(0, 1, 32'h0101, 1'b1); push_exp(0, 2, 32'h0201, 1'b1);
    push_exp(0, 0, 32'h0002, 1'b1); push_exp(0, 1, 32'h0102, 1'b1); push_exp(0, 2, 32'h0202, 1'b1);
    for (int k = 0; k < 6; k++) begin
      cycle(0, 1'b1, '1);
      chk("t2_no_bubble", 64'(acc[0] != '0), 64'(1));
    end
    repeat (2) cycle(0, 1'b1, '1);
    chk("t2_drained", 64'(q_a.size()), 64'(0));

    // Burst lock under toggling back-pressure
    do_reset(0);
    load(0, 1, 32'h0111, 1'b0); load(0, 1, 32'h0112, 1'b0);
    load(0, 1, 32'h0113, 1'b0); load(0, 1, 32'h0114, 1'b1);
    load(0, 3, 32'h0311, 1'b1);
    push_exp(0, 1, 32'h0111, 1'b0); push_exp(0, 1, 32'h0112, 1'b0);
    push_exp(0, 1, 32'h0113, 1'b0); push_exp(0, 1, 32'h0114, 1'b1);
    push_exp(0, 3, 32'h0311, 1'b1);
    for (int k = 0; k < 12; k++) begin
      cycle(0, (k % 2) == 0, '1);
      if (h[0][1] < 4) chk("t3_rdy3_low", 64'(ifa.in_ready[3]), 64'(0));
      if (ifa.out_valid && !ifa.out_ready) chk("t3_backpressure", 64'(ifa.in_ready), 64'(0));
    end
    chk("t3_drained", 64'(q_a.size()), 64'(0));

    // Enable mask excludes requester 1 until it is set
    do_reset(0);
    for (int b = 1; b <= 3; b++) begin
      load(0, 0, DW'(b), 1'b1);
      load(0, 2, DW'(512 + b), 1'b1);
      load(0, 3, DW'(768 + b), 1'b1);
    end
    load(0, 1, 32'h0101, 1'b1);
    push_exp(0, 0, 32'h0001, 1'b1); push_exp(0, 2, 32'h0201, 1'b1); push_exp(0, 3, 32'h0301, 1'b1);
    push_exp(0, 0, 32'h0002, 1'b1); push_exp(0, 2, 32'h0202, 1'b1); push_exp(0, 3, 32'h0302, 1'b1);
    push_exp(0, 0, 32'h0003, 1'b1); push_exp(0, 1, 32'h0101, 1'b1);
    push_exp(0, 2, 32'h0203, 1'b1); push_exp(0, 3, 32'h0303, 1'b1);
    for (int k = 0; k < 6; k++) begin
      cycle(0, 1'b1, 4'b1101);
      chk("t5_masked", 64'(ifa.in_ready[1]), 64'(0));
    end
    cycle(0, 1'b1, 4'b1111);
    cycle(0, 1'b1, 4'b1111);
    chk("t5_grant1", 64'(acc[0]), 64'(4'b0010));
    repeat (4) cycle(0, 1'b1, 4'b1111);
    chk("t5_drained", 64'(q_a.size()), 64'(0));

    // Reset in the middle of a burst from requester 2
    do_reset(0);
    load(0, 2, 32'h0221, 1'b0); load(0, 2, 32'h0222, 1'b0);
    load(0, 2, 32'h0223, 1'b0); load(0, 2, 32'h0224, 1'b1);
    push_exp(0, 2, 32'h0221, 1'b0);
    cycle(0, 1'b1, '1);
    cycle(0, 1'b1, '1);
    chk("t6_busy_pre", 64'(ifa.busy), 64'(1));
    do_reset(0);
    chk("t6_drained_pre", 64'(q_a.size()), 64'(0));
    load(0, 0, 32'h0031, 1'b1); load(0, 2, 32'h0231, 1'b1);
    push_exp(0, 0, 32'h0031, 1'b1); push_exp(0, 2, 32'h0231, 1'b1);
    repeat (4) cycle(0, 1'b1, '1);
    chk("t6_drained", 64'(q_a.size()), 64'(0));

    // Forced release after two beats (dut_b)
    for (int b = 1; b <= 5; b++) load(1, 2, DW'(576 + b), 1'b0);
    push_exp(1, 2, 32'h0241, 1'b0); push_exp(1, 2, 32'h0242, 1'b1);
    push_exp(1, 0, 32'h0041, 1'b1);
    push_exp(1, 2, 32'h0243, 1'b0); push_exp(1, 2, 32'h0244, 1'b1);
    push_exp(1, 2, 32'h0245, 1'b0);
    cycle(1, 1'b1, '1);
    load(1, 0, 32'h0041, 1'b1);
    repeat (7) cycle(1, 1'b1, '1);
    chk("t4_drained", 64'(q_b.size()), 64'(0));
    chk("t4_busy_locked", 64'(ifb.busy), 64'(1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
